tile_renderer: RTL

TILE_RENDERER -- requirements
Module: tile_renderer

---
 rtl/tile_renderer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/tile_renderer.sv
// Rectangle fill engine: accepts one clipped rectangle at a time and streams
// its pixels in row-major order, one per cycle, to the vga_adapter.
module tile_renderer #(
    parameter int unsigned SCREEN_WIDTH  = 160,
    parameter int unsigned SCREEN_HEIGHT = 120,
    parameter int unsigned COLOR_DEPTH   = 9,
    parameter int unsigned nX            = 8,
    parameter int unsigned nY            = 7
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [nX-1:0]          req_x,
    input  logic [nY-1:0]          req_y,
    input  logic [nX-1:0]          req_w,
    input  logic [nY-1:0]          req_h,
    input  logic [COLOR_DEPTH-1:0] req_color,
    output logic [nX-1:0]          x,
    output logic [nY-1:0]          y,
    output logic [COLOR_DEPTH-1:0] color,
    output logic                   write,
    output logic                   done
);

    localparam int unsigned XW = nX + 1;
    localparam int unsigned YW = nY + 1;

    typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;

    state_t        state;
    logic [nX-1:0] x_start;
    logic [nX-1:0] x_last;
    logic [nY-1:0] y_last;

    logic [XW-1:0] x_end_c;
    logic [YW-1:0] y_end_c;
    logic [nX-1:0] clip_x_c;
    logic [nY-1:0] clip_y_c;
    logic          empty_c;
    logic          single_c;
    logic          accept_c;
    logic [nX-1:0] next_x_c;
    logic [nY-1:0] next_y_c;
    logic          next_last_c;

    // Clip the incoming request; one extra bit keeps the sums from wrapping.
    always_comb begin
        x_end_c  = XW'(req_x) + XW'(req_w) - XW'(1);
        y_end_c  = YW'(req_y) + YW'(req_h) - YW'(1);
        clip_x_c = (x_end_c > XW'(SCREEN_WIDTH - 1))  ? nX'(SCREEN_WIDTH - 1)  : x_end_c[nX-1:0];
        clip_y_c = (y_end_c > YW'(SCREEN_HEIGHT - 1)) ? nY'(SCREEN_HEIGHT - 1) : y_end_c[nY-1:0];
        empty_c  = (req_w == '0) || (req_h == '0) ||
                   (XW'(req_x) >= XW'(SCREEN_WIDTH)) || (YW'(req_y) >= YW'(SCREEN_HEIGHT));
        single_c = (req_x == clip_x_c) && (req_y == clip_y_c);
        accept_c = req_valid && req_ready;
    end

    // Raster step: wrap to the left edge at the end of each row.
    always_comb begin
        next_x_c = x + nX'(1);
        next_y_c = y;
        if (x == x_last) begin
            next_x_c = x_start;
            next_y_c = y + nY'(1);
        end
        next_last_c = (next_x_c == x_last) && (next_y_c == y_last);
    end

    // Outputs are updated with the state so the pixel on the bus and done
    // always describe the same cycle; FINISH is the cycle holding done.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            color     <= '0;
            write     <= 1'b0;
            done      <= 1'b0;
            req_ready <= 1'b1;
            x_start   <= '0;
            x_last    <= '0;
            y_last    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    write <= 1'b0;
                    done  <= 1'b0;
                    if (accept_c) begin
                        req_ready <= 1'b0;
                        x_start   <= req_x;
                        x_last    <= clip_x_c;
                        y_last    <= clip_y_c;
                        if (empty_c) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            x     <= req_x;
                            y     <= req_y;
                            color <= req_color;
                            write <= 1'b1;
                            if (single_c) begin
                                state <= FINISH;
                                done  <= 1'b1;
                            end else begin
                                state <= DRAW;
                            end
                        end
                    end
                end
                DRAW: begin
                    x     <= next_x_c;
                    y     <= next_y_c;
                    write <= 1'b1;
                    if (next_last_c) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    write     <= 1'b0;
                    done      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    write     <= 1'b0;
                    done      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
